// File: rtl/micro_pkg.sv
// Shared state encoding, opcode and mux select constants for the multicycle RV32I control path.
package micro_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEMADR   = 4'd3,
        ST_MEMREAD  = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_MEMWRITE = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_EXEC_I   = 4'd8,
        ST_LUI      = 4'd9,
        ST_AUIPC    = 4'd10,
        ST_ALUWB    = 4'd11,
        ST_BRANCH   = 4'd12,
        ST_JAL      = 4'd13,
        ST_TRAP     = 4'd14
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [2:0] ALUOP_R   = 3'b000;
    localparam logic [2:0] ALUOP_B   = 3'b001;
    localparam logic [2:0] ALUOP_LS  = 3'b010;
    localparam logic [2:0] ALUOP_I   = 3'b011;
    localparam logic [2:0] ALUOP_ADD = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access; expired flags the cycle that reaches the limit.
// Combinational expired output from registered count; ready or clear restarts the count.
module mem_wait_timer
    import micro_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic active,
    input  logic ready,
    input  logic clear,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (active && !ready && !clear) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // cnt_q holds the stalled cycles before this one, so this cycle is number cnt_q+1.
    assign expired = active && !ready && (cnt_q >= LAST);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core: sequences the shared ALU and memory handshakes.
// Moore outputs except mem_ready/zero-gated enables; memory stalls are bounded by a timeout trap.
module multicycle_control
    import micro_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 8
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state_dbg
);

    state_e state_q;
    state_e state_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   timeout_q;
    logic   timeout_d;
    logic   mem_state;
    logic   expired;
    logic   state_change;

    assign mem_state    = (state_q == ST_FETCH) || (state_q == ST_MEMREAD) || (state_q == ST_MEMWRITE);
    assign state_change = (state_d != state_q);

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .active  (mem_state),
        .ready   (mem_ready),
        .clear   (state_change),
        .expired (expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)    state_d = ST_DECODE;
                else if (expired) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = ST_MEMADR;
                    OP_R:              state_d = ST_EXEC_R;
                    OP_I:              state_d = ST_EXEC_I;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL:            state_d = ST_JAL;
                    OP_LUI:            state_d = ST_LUI;
                    OP_AUIPC:          state_d = ST_AUIPC;
                    default:           state_d = ST_TRAP;
                endcase
            end
            // opcode[5] separates STORE (0100011) from LOAD (0000011).
            ST_MEMADR: state_d = opcode[5] ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD: begin
                if (mem_ready)    state_d = ST_MEMWB;
                else if (expired) state_d = ST_TRAP;
            end
            ST_MEMWRITE: begin
                if (mem_ready)    state_d = ST_FETCH;
                else if (expired) state_d = ST_TRAP;
            end
            ST_MEMWB, ST_ALUWB, ST_BRANCH:                 state_d = ST_FETCH;
            ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC, ST_JAL: state_d = ST_ALUWB;
            ST_TRAP:                                        state_d = ST_TRAP;
            default:                                        state_d = ST_IDLE;
        endcase
    end

    // TRAP is terminal, so only one cause can ever be recorded.
    always_comb begin
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        if (state_q == ST_DECODE && state_d == ST_TRAP && !timeout_q) illegal_d = 1'b1;
        if (expired && !mem_ready && !illegal_q)                     timeout_d = 1'b1;
    end

    always_comb begin
        ALUOp     = ALUOP_R;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            ST_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_LS;
            end
            ST_MEMREAD: begin
                MemRead = 1'b1;
                AdrSrc  = 1'b1;
            end
            ST_MEMWB: begin
                ResultSrc = RES_MEMDATA;
                RegWrite  = 1'b1;
            end
            ST_MEMWRITE: begin
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
            end
            ST_EXEC_R: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_R;
            end
            ST_EXEC_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_I;
            end
            ST_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_ADD;
            end
            ST_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOp     = ALUOP_B;
                ResultSrc = RES_ALUOUT;
                PCWrite   = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
            end
            // PC takes the target computed in DECODE while the ALU forms the link value.
            ST_JAL: begin
                PCWrite   = 1'b1;
                ResultSrc = RES_ALUOUT;
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ALUOp     = ALUOP_ADD;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign illegal   = illegal_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule
